// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives PC to a combinational ROM and queues {pc, instr} for decode; one word/cycle, head visible one cycle after fetch.
// Backpressure: a full queue stalls the PC unless the head is popped the same cycle; redirect flushes everything and wins over all else.
module fetch_sequencer #(
    parameter int unsigned MEM_SIZE = 1024,
    parameter int unsigned QDEPTH   = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    input  logic        out_ready,
    output logic        fetch_halted
);

    localparam int unsigned PTR_W   = $clog2(QDEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    // Last fetchable word address; comparing against this avoids the PC+3 overflow.
    localparam logic [63:0] LAST_PC = 64'(MEM_SIZE) - 64'd4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [63:0]        pc_mem    [QDEPTH];
    logic [31:0]        instr_mem [QDEPTH];

    logic               pc_ok;
    logic               full;
    logic               push;
    logic               pop;

    assign imem_address = pc_q;
    assign out_valid    = (count_q != '0);
    assign out_instr    = out_valid ? instr_mem[head_q] : 32'h0;
    assign out_pc       = out_valid ? pc_mem[head_q] : 64'h0;
    assign fetch_halted = (state_q == ST_HALT);

    always_comb begin
        pc_ok   = (pc_q <= LAST_PC) && (pc_q[1:0] == 2'b00);
        full    = (count_q == CNT_W'(QDEPTH));
        pop     = out_valid & out_ready;
        push    = (state_q == ST_RUN) && pc_ok && (!full || pop) && !redirect_valid;

        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (redirect_valid) begin
            // A pop in this cycle still counts as taken by decode; the flush discards the rest.
            state_d = ST_RUN;
            pc_d    = redirect_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
                pc_d   = pc_q + 64'd4;
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (state_q == ST_RUN && !pc_ok) begin
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]    <= pc_q;
            instr_mem[tail_q] <= imem_instruction;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: queue-based reference model compared every cycle, plus directed literal checks.
module tb_fetch_sequencer;

    localparam int unsigned MEM_SIZE = 1024;
    localparam int unsigned QDEPTH   = 4;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [63:0] LAST_PC  = 64'(MEM_SIZE - 4);

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] imem_address;
    logic [31:0] imem_instruction;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_ready = 1'b0;
    logic        fetch_halted;

    int errors = 0;
    int checks = 0;
    logic [31:0] salt = 32'h0;

    fetch_sequencer #(
        .MEM_SIZE (MEM_SIZE),
        .QDEPTH   (QDEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_instr        (out_instr),
        .out_pc           (out_pc),
        .out_ready        (out_ready),
        .fetch_halted     (fetch_halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [63:0] a);
        return a[33:2] ^ salt;
    endfunction

    assign imem_instruction = rom(imem_address);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: queue of fetched entries, a PC, and a halted flag.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc = RESET_PC;
    logic        m_halt = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_pc   = RESET_PC;
            m_halt = 1'b0;
        end else if (redirect_valid) begin
            mq.delete();
            m_pc   = redirect_pc;
            m_halt = 1'b0;
        end else begin
            if (mq.size() != 0 && out_ready) mq.delete(0);
            if (!m_halt) begin
                if (m_pc <= LAST_PC && m_pc[1:0] == 2'b00) begin
                    if (mq.size() < QDEPTH) begin
                        mq.push_back('{pc: m_pc, instr: rom(m_pc)});
                        m_pc = m_pc + 64'd4;
                    end
                end else begin
                    m_halt = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model imem_address", imem_address, m_pc);
        chk("model fetch_halted", 64'(fetch_halted), 64'(m_halt));
        chk("model out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("model out_pc", out_pc, (mq.size() != 0) ? mq[0].pc : 64'h0);
        chk("model out_instr", 64'(out_instr), (mq.size() != 0) ? 64'(mq[0].instr) : 64'h0);
    end

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    function automatic logic [63:0] pick_pc();
        case ($urandom_range(0, 4))
            0, 1:    return 64'($urandom_range(0, 255)) * 64'd4;
            2:       return 64'(MEM_SIZE) - 64'd4 * 64'($urandom_range(1, 6));
            3:       return 64'($urandom_range(0, 255)) * 64'd4 + 64'($urandom_range(1, 3));
            default: return ($urandom_range(0, 1) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'(MEM_SIZE);
        endcase
    endfunction

    initial begin
        logic [63:0] last_pc;

        // Free run, ROM word k = k.
        out_ready = 1'b1;
        do_reset();
        @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset imem_address", imem_address, RESET_PC);
        chk("reset out_pc", out_pc, 64'h0);
        chk("reset fetch_halted", 64'(fetch_halted), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("freerun out_pc", out_pc, 64'(k * 4));
            chk("freerun out_instr", 64'(out_instr), 64'(k));
        end

        // Backpressure: fill, hold, then one pop+push.
        out_ready = 1'b0;
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        chk("full imem_address", imem_address, 64'd16);
        chk("full out_pc", out_pc, 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("poppush imem_address", imem_address, 64'd20);
        chk("poppush out_pc", out_pc, 64'd4);
        chk("poppush out_valid", 64'(out_valid), 64'd1);

        // Redirect while full.
        redirect(64'h40);
        chk("redir out_valid", 64'(out_valid), 64'd0);
        chk("redir imem_address", imem_address, 64'h40);
        tick();
        chk("redir+2 out_pc", out_pc, 64'h40);
        chk("redir+2 out_instr", 64'(out_instr), 64'h10);

        // Run off the end of the ROM.
        out_ready = 1'b1;
        redirect(64'h3F0);
        last_pc = 64'h0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) last_pc = out_pc;
            if (fetch_halted) break;
        end
        chk("end fetch_halted", 64'(fetch_halted), 64'd1);
        chk("end imem_address", imem_address, 64'h400);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid) last_pc = out_pc;
        end
        chk("end last out_pc", last_pc, 64'h3FC);
        chk("end drained", 64'(out_valid), 64'd0);
        redirect(64'h0);
        chk("resume fetch_halted", 64'(fetch_halted), 64'd0);
        tick();
        chk("resume out_pc", out_pc, 64'h0);
        chk("resume out_valid", 64'(out_valid), 64'd1);

        // Misaligned redirect.
        redirect(64'h42);
        chk("mis run fetch_halted", 64'(fetch_halted), 64'd0);
        chk("mis imem_address", imem_address, 64'h42);
        tick();
        chk("mis halt fetch_halted", 64'(fetch_halted), 64'd1);
        chk("mis out_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset with the queue half full.
        out_ready = 1'b0;
        redirect(64'h80);
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("half out_valid", 64'(out_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async out_valid", 64'(out_valid), 64'd0);
        chk("async imem_address", imem_address, RESET_PC);
        tick();
        reset_n = 1'b1;
        tick();
        chk("restart out_pc", out_pc, RESET_PC);

        // Randomized traffic checked by the model.
        salt = $urandom;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = pick_pc();
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
        end
        redirect_valid = 1'b0;
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch controller for the out-of-order core. It owns the program counter and drives the word address into the combinational instruction ROM every cycle. Each returned instruction word is buffered with its PC in a small in-order fetch queue that feeds decode over a valid/ready handshake. It also handles branch/ROB redirects with a full flush, and stops cleanly when the PC leaves the ROM or becomes misaligned.

## Interface
Parameters:
- MEM_SIZE, 1024: instruction ROM size in bytes; must be a power of two.
- QDEPTH, 4: fetch queue depth in entries; must be a power of two, at least 2.
- RESET_PC, 64'h0: PC loaded at reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_address  out  64  byte address to the instruction ROM; equals the current PC.
- imem_instruction  in  32  ROM read data, valid in the same cycle as imem_address.
- redirect_valid  in  1  flush-and-redirect request from branch resolution or the ROB.
- redirect_pc  in  64  new fetch PC; sampled when redirect_valid=1.
- out_valid  out  1  queue head holds a valid entry.
- out_instr  out  32  instruction at the queue head; 0 when empty.
- out_pc  out  64  PC of the queue head; 0 when empty.
- out_ready  in  1  decode accepts the head this cycle.
- fetch_halted  out  1  sequencer is in HALT.

## Operation
- State machine with two states, RUN and HALT. Reset enters RUN.
- Queue: circular buffer with head, tail and count, where count ranges 0..QDEPTH. Head and tail wrap modulo QDEPTH.
- pop = out_valid & out_ready.
- push = (state==RUN) & in_bounds & aligned & (count<QDEPTH | pop) & ~redirect_valid.
  - in_bounds means PC+3 < MEM_SIZE, computed in 64-bit without overflow: PC ≤ MEM_SIZE-4.
  - aligned means PC[1:0]==0.
- A push writes {PC, imem_instruction} at the tail and advances PC by 4.
- A simultaneous push and pop leaves count unchanged. This is legal when full.
- In RUN, if PC is out of bounds or misaligned, there is no push and the next state is HALT. The queue keeps draining normally.
- HALT: no pushes, and PC holds. Leaving HALT requires a redirect or a reset.
- Redirect has the highest priority, in any state. On the edge:
  - count, head and tail are set to 0.
  - PC is set to redirect_pc.
  - The next state is RUN.
  - Any pop asserted in the same cycle is still considered accepted by decode, but the queue is flushed regardless.
- A redirect to an out-of-bounds or misaligned PC enters RUN, then moves to HALT on the following edge without pushing.
- imem_address = PC in every state, with no gating.

## Timing
- Reset values: PC=RESET_PC, count=0, head=tail=0, state=RUN, out_valid=0, out_instr=0, out_pc=0, fetch_halted=0, imem_address=RESET_PC.
- Fetch latency: the word fetched in cycle N is visible at the head in cycle N+1 if the queue was empty.
- Redirect latency: redirect asserted in cycle N gives imem_address=redirect_pc in N+1, and out_valid=1 with out_pc=redirect_pc in N+2.
- Throughput: 1 instruction/cycle when out_ready is held high.
- out_valid, out_instr and out_pc are functions of registered queue state only. There is no combinational path from out_ready or redirect_valid to these outputs.
- fetch_halted is high in the cycle after the offending PC is detected.
- Reset asserted mid-operation clears state immediately (asynchronously); the queue contents are discarded.

## Test plan
- Reset then free-run with out_ready=1 and ROM word k = k: out_pc sequences 0,4,8,… with out_instr = 0,1,2,… and one entry per cycle.
- Backpressure with out_ready=0: after 4 pushes, count=4 and PC=16. PC holds while full. Raising out_ready for 1 cycle gives pop and push together, count stays 4, PC=20.
- Redirect while full, redirect_pc=0x40: the next cycle has out_valid=0 and imem_address=0x40. Two cycles after the redirect, out_pc=0x40.
- Run off the end with MEM_SIZE=1024: the last out_pc is 0x3FC, fetch_halted=1 after PC=0x400, and the queue drains fully. A redirect to 0x0 then resumes fetching.
- Misaligned redirect to 0x42: RUN for one cycle, then HALT with no entries pushed.
- Assert reset_n=0 asynchronously mid-stream with the queue half full: out_valid drops immediately, and fetching restarts from RESET_PC after release.
